shift_add_datapath: RTL and testbench

- Datapath for the shift-add multiplier, directly downstream of the Control FSM.
- Consumes the Control outputs Load, Sh and Ad.
- Returns the status bits M (current multiplier LSB) and K (last shift pending) to Control.
- Holds the accumulator/multiplier register, the multiplicand register, the adder and the shift counter, and presents the 2N-bit product.

---
 rtl/mult_pkg.sv | 24 ++
 rtl/shift_counter.sv | 34 +++
 rtl/shift_add_datapath.sv | 97 +++++++++
 tb/tb_shift_add_datapath.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: default width, command
// encoding and the counter-width helper.
package mult_pkg;

    localparam int unsigned MULT_N = 4;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_LOAD  = 2'd1,
        CMD_ADD   = 2'd2,
        CMD_SHIFT = 2'd3
    } cmd_e;

    // Ceiling log2, usable in constant expressions
    function automatic int unsigned mult_cw(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/shift_counter.sv
// Shift counter for the multiplier datapath: counts 0..N-1 and wraps,
// flagging the last shift position.
module shift_counter #(
    parameter int unsigned N  = 4,
    parameter int unsigned CW = 2
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic term_o
);

    localparam logic [CW-1:0] TERM = CW'(N - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = (cnt_q == TERM) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign term_o = (cnt_q == TERM);

endmodule

// File: rtl/shift_add_datapath.sv
// Shift-add multiplier datapath: accumulator/multiplier, multiplicand, adder
// and shift counter. Define MULT_PROD_HOLD_EN to latch the product on Done.
module shift_add_datapath
    import mult_pkg::*;
#(
    parameter int unsigned N = MULT_N
) (
    input  logic           Clk,
    input  logic           Rst_n,
    input  logic           Load,
    input  logic           Sh,
    input  logic           Ad,
`ifdef MULT_PROD_HOLD_EN
    input  logic           Done,
`endif
    input  logic [N-1:0]   Mplier,
    input  logic [N-1:0]   Mcand,
    output logic           M,
    output logic           K,
    output logic [2*N-1:0] Product
);

    localparam int unsigned CW = mult_cw(N);

    logic [2*N:0] acc_q, acc_d;
    logic [N-1:0] mc_q, mc_d;
    logic [N:0]   sum_c;
    cmd_e         cmd_c;

    // Load > Ad > Sh
    always_comb begin
        cmd_c = CMD_NONE;
        if (Load)    cmd_c = CMD_LOAD;
        else if (Ad) cmd_c = CMD_ADD;
        else if (Sh) cmd_c = CMD_SHIFT;
    end

    // Carry lands in bit 2N; the previous carry is overwritten, never summed
    assign sum_c = {1'b0, acc_q[2*N-1:N]} + {1'b0, mc_q};

    always_comb begin
        acc_d = acc_q;
        mc_d  = mc_q;
        case (cmd_c)
            CMD_LOAD: begin
                acc_d = {(N + 1)'(0), Mplier};
                mc_d  = Mcand;
            end
            CMD_ADD:   acc_d[2*N:N] = sum_c;
            CMD_SHIFT: acc_d = {1'b0, acc_q[2*N:1]};
            default:   ;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            acc_q <= '0;
            mc_q  <= '0;
        end else begin
            acc_q <= acc_d;
            mc_q  <= mc_d;
        end
    end

    shift_counter #(
        .N  (N),
        .CW (CW)
    ) u_cnt (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .clr_i  (cmd_c == CMD_LOAD),
        .inc_i  (cmd_c == CMD_SHIFT),
        .term_o (K)
    );

    assign M = acc_q[0];

`ifdef MULT_PROD_HOLD_EN
    logic [2*N-1:0] pr_q, pr_d;

    // Captures the pre-edge accumulator so the result survives the next run
    always_comb begin
        pr_d = pr_q;
        if (Done) pr_d = acc_q[2*N-1:0];
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) pr_q <= '0;
        else        pr_q <= pr_d;
    end

    assign Product = pr_q;
`else
    assign Product = acc_q[2*N-1:0];
`endif

endmodule

// File: tb/tb_shift_add_datapath.sv
// Scoreboard bench for shift_add_datapath: an arithmetic model predicts each
// post-edge output; a monitor compares once per cycle.
module tb_shift_add_datapath;

    localparam int unsigned     TN   = 4;
    localparam longint unsigned HALF = 64'd1 << TN;
    localparam longint unsigned FULL = HALF * HALF;
`ifdef MULT_PROD_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic            Clk    = 1'b0;
    logic            Rst_n  = 1'b0;
    logic            Load   = 1'b1;
    logic            Sh     = 1'b0;
    logic            Ad     = 1'b0;
`ifdef MULT_PROD_HOLD_EN
    logic            Done   = 1'b0;
`endif
    logic [TN-1:0]   Mplier = '1;
    logic [TN-1:0]   Mcand  = '0;
    logic            M;
    logic            K;
    logic [2*TN-1:0] Product;

    shift_add_datapath #(.N(TN)) dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .Load    (Load),
        .Sh      (Sh),
        .Ad      (Ad),
`ifdef MULT_PROD_HOLD_EN
        .Done    (Done),
`endif
        .Mplier  (Mplier),
        .Mcand   (Mcand),
        .M       (M),
        .K       (K),
        .Product (Product)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic            m;
        logic            k;
        logic [2*TN-1:0] prod;
        string           tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model state: accumulator as a plain integer, shift position 0..TN-1
    longint unsigned m_acc = 0, m_mc = 0, m_pr = 0;
    int unsigned     m_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // One command cycle: drive at negedge, predict the state after the next posedge
    task automatic step(input bit ld, input bit ad, input bit sh, input bit dn,
                        input logic [TN-1:0] mp, input logic [TN-1:0] mcd,
                        input bit lit_en, input longint unsigned lit, input string tag);
        exp_t e;
        @(negedge Clk);
        Load = ld; Ad = ad; Sh = sh; Mplier = mp; Mcand = mcd;
`ifdef MULT_PROD_HOLD_EN
        Done = dn;
`endif
        if (ad && sh) $display("note: %s drives Ad and Sh together (Control protocol violation)", tag);
        if (HOLD && dn) m_pr = m_acc % FULL;
        if (ld) begin
            m_acc = 64'(mp);
            m_mc  = 64'(mcd);
            m_cnt = 0;
        end else if (ad) begin
            m_acc = (((m_acc / HALF) % HALF) + m_mc) * HALF + (m_acc % HALF);
        end else if (sh) begin
            m_acc = m_acc / 2;
            m_cnt = (m_cnt + 1) % TN;
        end
        e.m    = (m_acc % 2) == 1;
        e.k    = (m_cnt == TN - 1);
        e.prod = HOLD ? (2*TN)'(m_pr) : (2*TN)'(m_acc % FULL);
        if (lit_en && (!HOLD || dn)) e.prod = (2*TN)'(lit);
        e.tag  = tag;
        exp_q.push_back(e);
    endtask

    // Protocol-following multiply: Ad when the bit under test is 1, then Sh, TN times
    task automatic multiply(input logic [TN-1:0] a, input logic [TN-1:0] b, input string tag);
        longint unsigned p;
        p = 64'(a) * 64'(b);
        step(1, 0, 0, 0, a, b, 0, 0, {tag, "/load"});
        for (int i = 0; i < TN; i++) begin
            if ((m_acc % 2) == 1) step(0, 1, 0, 0, 4'($urandom()), 4'($urandom()), 0, 0, {tag, "/ad"});
            step(0, 0, 1, 0, 4'($urandom()), 4'($urandom()), i == TN - 1, p, {tag, "/sh"});
        end
        step(0, 0, 0, 1, 4'($urandom()), 4'($urandom()), 1, p, {tag, "/done"});
        step(0, 0, 0, 0, 4'($urandom()), 4'($urandom()), 1, p, {tag, "/hold"});
    endtask

    task automatic async_reset(input string tag);
        @(posedge Clk);
        #3;
        Load = 1'b1; Mplier = '1; Ad = 1'b0; Sh = 1'b0;
        Rst_n = 1'b0;
        #1;
        check({tag, "/M"}, 64'(M), 64'd0);
        check({tag, "/K"}, 64'(K), 64'd0);
        check({tag, "/Product"}, 64'(Product), 64'd0);
        m_acc = 0; m_mc = 0; m_cnt = 0; m_pr = 0;
        @(posedge Clk);
        #2;
        check({tag, "/Product_in_reset"}, 64'(Product), 64'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        Load  = 1'b0;
    endtask

    // Monitor: outputs are Moore, compared once per cycle after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("%s/M", e.tag), 64'(M), 64'(e.m));
                check($sformatf("%s/K", e.tag), 64'(K), 64'(e.k));
                check($sformatf("%s/Product", e.tag), 64'(Product), 64'(e.prod));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with Load=1, Mplier=F: nothing may be captured
        repeat (2) @(posedge Clk);
        #2;
        check("por/M", 64'(M), 64'd0);
        check("por/K", 64'(K), 64'd0);
        check("por/Product", 64'(Product), 64'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        Load  = 1'b0;
        step(0, 0, 0, 0, '1, '1, 1, 0, "por_idle0");
        step(0, 0, 0, 0, '1, '1, 1, 0, "por_idle1");

        multiply(4'hB, 4'hD, "mul_b_d");
        check("mul_b_d/literal", 64'(HOLD ? 8'h8F : Product), 64'h8F);
        multiply(4'hF, 4'hF, "mul_f_f");
        multiply(4'h0, 4'h9, "mul_0_9");

        // Ad and Sh together: Ad wins, counter unchanged
        step(1, 0, 0, 0, 4'h0, 4'h3, 0, 0, "adsh/load");
        step(0, 1, 1, 0, 4'h0, 4'h0, 1, 64'h30, "adsh/both");
        step(0, 0, 1, 0, 4'h0, 4'h0, 1, 64'h18, "adsh/sh");
        async_reset("midop_reset");
        step(0, 0, 0, 0, '1, '1, 1, 0, "post_reset");

        for (int t = 0; t < 20; t++) begin
            multiply(4'($urandom()), 4'($urandom()), $sformatf("rnd%0d", t));
            repeat ($urandom_range(0, 3)) begin
                int unsigned c;
                c = $urandom_range(0, 2);
                step(0, c == 1, c == 2, 0, 4'($urandom()), 4'($urandom()), 0, 0,
                     $sformatf("rnd%0d/noise", t));
            end
        end

        repeat (3) @(negedge Clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
